hilo_md_unit: RTL and testbench

Parametrised HI/LO unit for the execute stage: holds the 2×WIDTH HI/LO register pair and owns multiply, iterative divide and MTHI/MTLO writes behind a valid/ready/done handshake. It supersedes the bare HI/LO register. It adds:
- a multi-cycle multiply,
- a radix-2 restoring divider,
- flush cancellation,
- a read port for MFHI/MFLO.

---
 rtl/hilo_md_unit_pkg.sv | 28 ++
 rtl/hilo_md_unit_div.sv | 107 ++++++++++
 rtl/hilo_md_unit.sv | 216 +++++++++++++++++++++
 tb/tb_hilo_md_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_md_unit_pkg.sv
// hilo_md_unit_pkg
//   Operation codes and FSM state encoding shared by the HI/LO unit,
//   its divider and anything that issues operations to it.
//   No ports; imported with "import hilo_md_unit_pkg::*;".
package hilo_md_unit_pkg;

  localparam logic [3:0] HILO_OP_MTHI  = 4'h0;
  localparam logic [3:0] HILO_OP_MTLO  = 4'h1;
  localparam logic [3:0] HILO_OP_MULT  = 4'h2;
  localparam logic [3:0] HILO_OP_MULTU = 4'h3;
  localparam logic [3:0] HILO_OP_DIV   = 4'h4;
  localparam logic [3:0] HILO_OP_DIVU  = 4'h5;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_MUL  = 2'd1,
    HILO_DIV  = 2'd2
  } hilo_state_e;

  function automatic logic is_mul_op(input logic [3:0] code);
    return (code == HILO_OP_MULT) || (code == HILO_OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] code);
    return (code == HILO_OP_DIV) || (code == HILO_OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_md_unit_div.sv
// hilo_div
//   Iterative radix-2 restoring divider, one quotient bit per clock edge.
//   Signed division works on magnitudes; the quotient is negated when the
//   operand signs differ and the remainder takes the dividend's sign.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               load operands (the divisor must be non-zero)
//   cancel              abandon the division in flight
//   is_signed           treat dividend/divisor as two's complement (sampled at start)
//   dividend, divisor   operands, sampled at start
//   done                high during the cycle whose rising edge performs the last iteration
//   quotient, remainder final results, valid while done is high
module hilo_div
  import hilo_md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             running;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // quo_q starts as the dividend magnitude and is shifted out MSB-first
  // into the partial remainder while quotient bits shift in at the bottom.
  // The partial remainder stays below the divisor, so one extra bit on the
  // shifted value is enough and its top bit of the trial difference is the
  // borrow.
  always_comb begin
    a_mag    = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag    = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Results come straight from the last iteration's next-state values so the
  // owner can capture them on the same edge that completes the division.
  // Most-negative / -1 falls out naturally: the magnitude quotient 2^(W-1)
  // negates to itself.
  assign quotient  = neg_quo_q ? -quo_next : quo_next;
  assign remainder = neg_rem_q ? -rem_next : rem_next;
  assign done      = running && (count == LAST) && !cancel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running   <= 1'b0;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (cancel) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running   <= 1'b1;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= a_mag;
      dsr_q     <= b_mag;
      neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_q <= is_signed && dividend[WIDTH-1];
    end else if (running) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      if (count == LAST) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hilo_md_unit.sv
// hilo_md_unit
//   Execute-stage HI/LO unit: owns the {HI, LO} register pair and performs
//   MTHI/MTLO, multi-cycle MULT/MULTU and iterative DIV/DIVU behind a
//   valid/ready/done handshake, with flush cancellation and an MFHI/MFLO
//   read port.
// Parameters:
//   WIDTH    data width (HI and LO are WIDTH bits each)
//   MUL_LAT  multiply latency in clock edges, 1..4
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   op_valid, op  operation request and HILO_OP_* code
//   src_a, src_b  rs / rt operands
//   flush         cancels the request and any operation in flight
//   op_ready      unit idle; op accepted on op_valid & op_ready & ~flush
//   busy          multiply or divide in flight
//   done          one-cycle completion pulse
//   div_by_zero   pulses with done for a divide whose divisor is zero
//   rd_sel        0 = LO, 1 = HI
//   rd_data       MFHI/MFLO read data
//   hilo          current {HI, LO}
// Build option:
//   HILO_FWD_EN   when defined, rd_data forwards src_a while an MTHI/MTLO
//                 writing the selected half is being accepted.
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               op_ready,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  input  logic               rd_sel,
  output logic [WIDTH-1:0]   rd_data,
  output logic [2*WIDTH-1:0] hilo
);

  localparam int HW = 2 * WIDTH;
  localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT - 1);

  hilo_state_e state;
  hilo_state_e state_next;

  logic [HW-1:0]    hilo_q;
  logic [2:0]       mul_cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_signed;
  logic [HW-1:0]    mul_ext_a;
  logic [HW-1:0]    mul_ext_b;
  logic [HW-1:0]    product;

  logic             accept;
  logic             mul_start;
  logic             div_start;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata_hi;
  logic [WIDTH-1:0] wdata_lo;
  logic             done_next;
  logic             dbz_next;

  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign op_ready = (state == HILO_IDLE);
  assign busy     = (state != HILO_IDLE);
  assign accept   = op_valid && op_ready && !flush;
  assign hilo     = hilo_q;

  // Sign- or zero-extending both operands to 2W bits lets a single
  // truncated 2W x 2W product serve MULT and MULTU alike.
  assign mul_ext_a = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
  assign mul_ext_b = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
  assign product   = mul_ext_a * mul_ext_b;

  hilo_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .cancel    (flush),
    .is_signed (op == HILO_OP_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HILO_IDLE;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      done        <= done_next;
      div_by_zero <= dbz_next;
    end
  end

  // Flush has priority over completion in MUL/DIV, so a flush on the final
  // edge discards the result.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    div_start  = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    wdata_hi   = src_a;
    wdata_lo   = src_a;
    done_next  = 1'b0;
    dbz_next   = 1'b0;
    case (state)
      HILO_IDLE: begin
        if (accept) begin
          if (op == HILO_OP_MTHI) begin
            wr_hi     = 1'b1;
            done_next = 1'b1;
          end else if (op == HILO_OP_MTLO) begin
            wr_lo     = 1'b1;
            done_next = 1'b1;
          end else if (is_mul_op(op)) begin
            mul_start  = 1'b1;
            state_next = HILO_MUL;
          end else if (is_div_op(op)) begin
            if (src_b == '0) begin
              done_next = 1'b1;
              dbz_next  = 1'b1;
            end else begin
              div_start  = 1'b1;
              state_next = HILO_DIV;
            end
          end else begin
            done_next = 1'b1;
          end
        end
      end
      HILO_MUL: begin
        if (flush) begin
          state_next = HILO_IDLE;
        end else if (mul_cnt == 3'd0) begin
          wr_hi      = 1'b1;
          wr_lo      = 1'b1;
          wdata_hi   = product[HW-1:WIDTH];
          wdata_lo   = product[WIDTH-1:0];
          done_next  = 1'b1;
          state_next = HILO_IDLE;
        end
      end
      HILO_DIV: begin
        if (flush) begin
          state_next = HILO_IDLE;
        end else if (div_done) begin
          wr_hi      = 1'b1;
          wr_lo      = 1'b1;
          wdata_hi   = div_rem;
          wdata_lo   = div_quo;
          done_next  = 1'b1;
          state_next = HILO_IDLE;
        end
      end
      default: state_next = HILO_IDLE;
    endcase
  end

  // Multiply operands are captured at acceptance so the requester may change
  // src_a/src_b while the product is pending; the counter is loaded so that
  // the result is written MUL_LAT edges after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      mul_cnt    <= 3'd0;
    end else if (mul_start) begin
      mul_a      <= src_a;
      mul_b      <= src_b;
      mul_signed <= (op == HILO_OP_MULT);
      mul_cnt    <= MUL_LOAD;
    end else if (flush) begin
      mul_cnt <= 3'd0;
    end else if (state == HILO_MUL && mul_cnt != 3'd0) begin
      mul_cnt <= mul_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_q <= '0;
    end else begin
      if (wr_hi) hilo_q[HW-1:WIDTH]  <= wdata_hi;
      if (wr_lo) hilo_q[WIDTH-1:0]   <= wdata_lo;
    end
  end

  always_comb begin
    rd_data = rd_sel ? hilo_q[HW-1:WIDTH] : hilo_q[WIDTH-1:0];
`ifdef HILO_FWD_EN
    if (accept && (op == HILO_OP_MTHI) && rd_sel)  rd_data = src_a;
    if (accept && (op == HILO_OP_MTLO) && !rd_sel) rd_data = src_a;
`endif
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// tb_hilo_md_unit
//   Scoreboard bench for hilo_md_unit (WIDTH = 32, MUL_LAT = 2): every issued
//   operation pushes its expected {HI, LO}, div_by_zero flag and completion
//   cycle; a monitor pops and compares whenever done is seen.
module tb_hilo_md_unit;
  import hilo_md_unit_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        rd_sel = 1'b0;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] rd_data;
  logic [63:0] hilo;

  hilo_md_unit #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .op_ready    (op_ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .hilo        (hilo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] hilo;
    logic        dbz;
    int          cycle;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vectors = 0;
  int          n_miscompares = 0;
  int          cycle = 0;
  logic [63:0] model_hilo = '0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: architectural result of one operation.
  function automatic void ref_model(input logic [3:0] f_op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [63:0] old,
                                    output logic [63:0] res, output logic dbz,
                                    output int lat);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    int          ia;
    int          ib;
    res = old;
    dbz = 1'b0;
    lat = 0;
    if (f_op == HILO_OP_MTHI) begin
      res = {a, old[31:0]};
    end else if (f_op == HILO_OP_MTLO) begin
      res = {old[63:32], a};
    end else if (f_op == HILO_OP_MULT) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = 64'(sa * sb);
      lat = MUL_LAT;
    end else if (f_op == HILO_OP_MULTU) begin
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      res = ua * ub;
      lat = MUL_LAT;
    end else if (f_op == HILO_OP_DIV) begin
      if (b == 32'h0) begin
        dbz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res = {32'h0, 32'h8000_0000};
        lat = WIDTH;
      end else begin
        ia  = $signed(a);
        ib  = $signed(b);
        res = {32'(ia % ib), 32'(ia / ib)};
        lat = WIDTH;
      end
    end else if (f_op == HILO_OP_DIVU) begin
      if (b == 32'h0) begin
        dbz = 1'b1;
      end else begin
        res = {a % b, a / b};
        lat = WIDTH;
      end
    end
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return c == HILO_OP_MTHI || c == HILO_OP_MTLO || c == HILO_OP_MULT ||
           c == HILO_OP_MULTU || c == HILO_OP_DIV || c == HILO_OP_DIVU;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one request across one rising edge. With expect_result the model
  // is advanced and the expected completion is queued for the monitor.
  task automatic apply_stimulus(input logic [3:0] t_op, input logic [31:0] a,
                                input logic [31:0] b, input bit expect_result,
                                input bit check_fwd);
    exp_t        e;
    logic [63:0] res;
    logic        dbz;
    int          lat;
    op_valid = 1'b1;
    op       = t_op;
    src_a    = a;
    src_b    = b;
    if (check_fwd) begin
      rd_sel = 1'b0;
      #1;
`ifdef HILO_FWD_EN
      check_output("mt_forward_rd", 64'(rd_data), 64'(a));
`else
      check_output("mt_forward_rd", 64'(rd_data), 64'(model_hilo[31:0]));
`endif
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    if (expect_result) begin
      ref_model(t_op, a, b, model_hilo, res, dbz, lat);
      e.hilo  = res;
      e.dbz   = dbz;
      e.cycle = cycle + lat;
      sb_q.push_back(e);
      model_hilo = res;
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && op_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL %s_timeout: got %0d pending results, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_read(input string name);
    rd_sel = 1'b1;
    #1;
    check_output({name, "_rd_hi"}, 64'(rd_data), 64'(model_hilo[63:32]));
    rd_sel = 1'b0;
    #1;
    check_output({name, "_rd_lo"}, 64'(rd_data), 64'(model_hilo[31:0]));
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        n_vectors++;
        if (sb_q.size() == 0) begin
          n_miscompares++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cycle);
        end else begin
          e = sb_q.pop_front();
          if (hilo !== e.hilo || div_by_zero !== e.dbz || cycle != e.cycle) begin
            n_miscompares++;
            $display("[TB] FAIL done_result: got hilo=0x%0h dbz=%0b cycle=%0d, expected hilo=0x%0h dbz=%0b cycle=%0d",
                     hilo, div_by_zero, cycle, e.hilo, e.dbz, e.cycle);
          end
        end
      end else if (rst && div_by_zero) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL stray_dbz: got div_by_zero=1 without done, expected 0");
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  r_op;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_hilo",     hilo,              64'h0);
    check_output("reset_op_ready", 64'(op_ready),     64'h1);
    check_output("reset_busy",     64'(busy),         64'h0);
    check_output("reset_done",     64'(done),         64'h0);
    check_output("reset_dbz",      64'(div_by_zero),  64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    apply_stimulus(HILO_OP_MTHI, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    apply_stimulus(HILO_OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);
    wait_idle("mt_pair");
    check_output("mt_pair_hilo", hilo, 64'h1234_5678_9ABC_DEF0);
    check_read("mt_pair");

    apply_stimulus(HILO_OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1, 1'b0);
    wait_idle("mult");
    check_output("mult_hilo", hilo, 64'hFFFF_FFFF_FFFF_FFFA);

    apply_stimulus(HILO_OP_MULTU, 32'hFFFF_FFFE, 32'h3, 1'b1, 1'b0);
    wait_idle("multu");
    check_output("multu_hilo", hilo, 64'h0000_0002_FFFF_FFFA);

    apply_stimulus(HILO_OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0);
    wait_idle("div_neg");
    check_output("div_neg_hilo", hilo, 64'hFFFF_FFFF_FFFF_FFFD);

    apply_stimulus(HILO_OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_idle("divu");
    check_output("divu_hilo", hilo, 64'h0000_0002_0000_000E);

    apply_stimulus(HILO_OP_DIV, 32'h55, 32'h0, 1'b1, 1'b0);
    check_output("dbz_op_ready", 64'(op_ready), 64'h1);
    check_output("dbz_busy",     64'(busy),     64'h0);
    wait_idle("dbz");
    check_output("dbz_hilo", hilo, 64'h0000_0002_0000_000E);

    apply_stimulus(HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_idle("div_minneg");
    check_output("div_minneg_hilo", hilo, 64'h0000_0000_8000_0000);

    // Flush part-way through a divide: no write, no done.
    apply_stimulus(HILO_OP_DIVU, 32'h0123_4567, 32'h3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check_output("flush_busy_before", 64'(busy), 64'h1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_output("flush_busy_after",  64'(busy),     64'h0);
    check_output("flush_op_ready",    64'(op_ready), 64'h1);
    check_output("flush_hilo",        hilo,          model_hilo);
    repeat (40) @(negedge clk);

    // Asynchronous reset during a divide.
    apply_stimulus(HILO_OP_MTHI, 32'hCAFE_0001, 32'h0, 1'b1, 1'b0);
    wait_idle("pre_reset");
    apply_stimulus(HILO_OP_DIVU, 32'hDEAD_BEEF, 32'h7, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_hilo = '0;
    check_output("midop_reset_hilo",     hilo,          64'h0);
    check_output("midop_reset_busy",     64'(busy),     64'h0);
    check_output("midop_reset_op_ready", 64'(op_ready), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // MTLO with a read of LO in the accept cycle.
    apply_stimulus(HILO_OP_MTLO, 32'h0000_AAAA, 32'h0, 1'b1, 1'b0);
    wait_idle("pre_fwd");
    apply_stimulus(HILO_OP_MTLO, 32'h0000_0055, 32'h0, 1'b1, 1'b1);
    wait_idle("fwd");
    check_output("fwd_hilo", hilo, 64'h0000_0000_0000_0055);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: r_op = HILO_OP_MTHI;
        1: r_op = HILO_OP_MTLO;
        2: r_op = HILO_OP_MULT;
        3: r_op = HILO_OP_MULTU;
        4: r_op = HILO_OP_DIV;
        5: r_op = HILO_OP_DIVU;
        default: begin
          do r_op = 4'($urandom_range(0, 15)); while (is_legal(r_op));
        end
      endcase
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      apply_stimulus(r_op, a, b, 1'b1, 1'b0);
      wait_idle("random");
      rd_sel = 1'($urandom_range(0, 1));
      #1;
      check_output("random_rd", 64'(rd_data),
                   64'(rd_sel ? model_hilo[63:32] : model_hilo[31:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
